// File: rtl/rs422_autobaud_pkg.sv
// Shared definitions for the RS422 auto-baud detector.
// FSM state encoding and 0x55 sync-byte geometry.
package rs422_autobaud_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2
  } ab_state_e;

  localparam int SYNC_EDGES = 8;
  localparam int SYNC_SHIFT = 3;

endpackage

// File: rtl/rs422_autobaud_rx_sync.sv
// 2-FF synchronizer plus edge detect for an async RX line.
// Shared with the UART receiver; idles high out of reset.
module rs422_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rx_s,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= rx;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rx_s = sync_q;
  assign rise = sync_q & ~prev_q;
  assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/rs422_autobaud.sv
// Auto-baud detector: times a 0x55 sync byte, emits baud_div = period-1.
// Define AUTOBAUD_TOL_CHECK_EN for per-interval +/-25% tolerance checking.
module rs422_autobaud
  import rs422_autobaud_pkg::*;
#(
  parameter int             CNT_W   = 32,
  parameter logic [CNT_W-1:0] MAX_CNT = 32'h00FF_FFFF,
  parameter logic [CNT_W-1:0] MIN_DIV = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx,
  input  logic             start,
  output logic [CNT_W-1:0] baud_div,
  output logic             valid,
  output logic             busy,
  output logic             err
);

  ab_state_e        state_q, state_d;
  logic [CNT_W-1:0] idle_q;
  logic [CNT_W-1:0] total_q;
  logic [2:0]       edge_cnt_q;
  logic             seen_high_q;
  logic [CNT_W-1:0] baud_div_q;
  logic             valid_q;
  logic             err_q;

  logic rx_s, rise, fall, edge_ev;
  logic [CNT_W-1:0] total_fin;
  logic [CNT_W-1:0] div_w;
  logic timeout, last_edge, tol_bad;
  logic arm, meas_start, edge_inc;
  logic load_p0, set_valid, set_err;

  rs422_rx_sync u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .rx   (rx),
    .rx_s (rx_s),
    .rise (rise),
    .fall (fall)
  );

  assign edge_ev   = rise | fall;
  assign total_fin = (&total_q) ? total_q
                                : total_q + CNT_W'(1);
  assign div_w     = ((total_fin + CNT_W'(4))
                      >> SYNC_SHIFT) - CNT_W'(1);
  assign timeout   = (idle_q == MAX_CNT - CNT_W'(1));
  assign last_edge =
    (edge_cnt_q == 3'(SYNC_EDGES - 1));

`ifdef AUTOBAUD_TOL_CHECK_EN
  logic [CNT_W-1:0] p0_q;
  logic [CNT_W-1:0] iv;
  logic [CNT_W-1:0] lo, hi;

  // idle_q restarts at every edge, so it tracks the open interval
  assign iv = idle_q + CNT_W'(1);
  assign lo = p0_q - (p0_q >> 2);
  assign hi = p0_q + (p0_q >> 2);
  assign tol_bad = (edge_cnt_q != 3'd0) &&
                   ((iv < lo) || (iv > hi));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) p0_q <= '0;
    else if (load_p0) p0_q <= iv;
  end
`else
  assign tol_bad = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    arm        = 1'b0;
    meas_start = 1'b0;
    edge_inc   = 1'b0;
    load_p0    = 1'b0;
    set_valid  = 1'b0;
    set_err    = 1'b0;
    if (start) begin
      state_d = ARMED;
      arm     = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: ;
        ARMED: begin
          if (fall && seen_high_q) begin
            state_d    = MEASURE;
            meas_start = 1'b1;
          end else if (timeout) begin
            state_d = IDLE;
            set_err = 1'b1;
          end
        end
        MEASURE: begin
          if (edge_ev) begin
            if (tol_bad) begin
              state_d = IDLE;
              set_err = 1'b1;
            end else if (last_edge) begin
              state_d = IDLE;
              if (div_w >= MIN_DIV) set_valid = 1'b1;
              else                  set_err   = 1'b1;
            end else begin
              edge_inc = 1'b1;
              load_p0  = (edge_cnt_q == 3'd0);
            end
          end else if (timeout) begin
            state_d = IDLE;
            set_err = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idle_q      <= '0;
      total_q     <= '0;
      edge_cnt_q  <= '0;
      seen_high_q <= 1'b0;
      baud_div_q  <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= set_valid;
      err_q   <= set_err;
      if (arm || (state_q != IDLE && edge_ev))
        idle_q <= '0;
      else if (state_q != IDLE)
        idle_q <= idle_q + CNT_W'(1);
      if (meas_start)
        total_q <= '0;
      else if (state_q == MEASURE)
        total_q <= total_fin;
      if (meas_start)
        edge_cnt_q <= '0;
      else if (edge_inc)
        edge_cnt_q <= edge_cnt_q + 3'd1;
      if (arm)
        seen_high_q <= 1'b0;
      else if (state_q == ARMED && rx_s)
        seen_high_q <= 1'b1;
      if (set_valid)
        baud_div_q <= div_w;
    end
  end

  assign baud_div = baud_div_q;
  assign valid    = valid_q;
  assign err      = err_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_rs422_autobaud.sv
// Bench for rs422_autobaud: randomized 0x55 frames vs an interval model.
// Build with AUTOBAUD_TOL_CHECK_EN to exercise the tolerance option.
module tb_rs422_autobaud;

  localparam int CW   = 32;
  localparam int MAXC = 1000;
  localparam int MIND = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx;
  logic          start;
  logic [CW-1:0] baud_div;
  logic          valid, busy, err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int v_cnt = 0, e_cnt = 0;
  int v_cyc = 0, e_cyc = 0;
  int ivs[8];
  int edge_cyc[9];
  logic [CW-1:0] exp_hold;

  rs422_autobaud #(
    .CNT_W  (CW),
    .MAX_CNT(32'(MAXC)),
    .MIN_DIV(32'(MIND))
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx      (rx),
    .start   (start),
    .baud_div(baud_div),
    .valid   (valid),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      v_cnt = v_cnt + 1;
      v_cyc = cyc;
    end
    if (err) begin
      e_cnt = e_cnt + 1;
      e_cyc = cyc;
    end
  end

  // Reference: 8 intervals -> divisor, or the edge that trips an error
  function automatic void ref_model(
    output int ev, output int ee, output int eidx,
    output logic [CW-1:0] ediv);
    int sum;
    int d;
    bit hit;
    sum  = 0;
    hit  = 1'b0;
    ev   = 0;
    ee   = 0;
    eidx = 8;
    ediv = exp_hold;
    for (int k = 0; k < 8; k++) sum += ivs[k];
`ifdef AUTOBAUD_TOL_CHECK_EN
    for (int k = 1; k < 8; k++) begin
      if (!hit && (ivs[k] < ivs[0] - ivs[0] / 4 ||
                   ivs[k] > ivs[0] + ivs[0] / 4)) begin
        hit  = 1'b1;
        eidx = k + 1;
      end
    end
`endif
    if (hit) begin
      ee = 1;
    end else begin
      d = (sum + 4) / 8 - 1;
      if (d < MIND) ee = 1;
      else begin
        ev   = 1;
        ediv = CW'(d);
      end
    end
  endfunction

  task automatic arm();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic drive_edges(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rx = ~rx;
      edge_cyc[k] = cyc;
      if (k < n - 1) repeat (ivs[k] - 1) @(negedge clk);
    end
  endtask

  task automatic run_frame(input string nm, input bit do_arm);
    int v0, e0, ev, ee, ei, lat;
    logic [CW-1:0] ed;
    v0 = v_cnt;
    e0 = e_cnt;
    ref_model(ev, ee, ei, ed);
    if (do_arm) arm();
    drive_edges(9);
    repeat (10) @(negedge clk);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    exp_hold = ed;
    total++;
    if (v_cnt - v0 !== ev) begin
      bad++;
      $display("FAIL %s valid_pulses got %0d want %0d",
               nm, v_cnt - v0, ev);
    end
    total++;
    if (e_cnt - e0 !== ee) begin
      bad++;
      $display("FAIL %s err_pulses got %0d want %0d",
               nm, e_cnt - e0, ee);
    end
    total++;
    if (baud_div !== exp_hold) begin
      bad++;
      $display("FAIL %s baud_div got %0d want %0d",
               nm, baud_div, exp_hold);
    end
    lat = (ev != 0) ? v_cyc - edge_cyc[ei]
                    : e_cyc - edge_cyc[ei];
    total++;
    if (lat !== 3) begin
      bad++;
      $display("FAIL %s latency got %0d want 3", nm, lat);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s busy_after got %b want 0", nm, busy);
    end
  endtask

  task automatic fill(input int p);
    for (int k = 0; k < 8; k++) ivs[k] = p;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx    = 1'b1;
    start = 1'b0;
    exp_hold = '0;
    repeat (3) @(negedge clk);
    total++;
    if (baud_div !== '0 || valid !== 1'b0 ||
        busy !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL reset outputs got div=%0d v=%b b=%b e=%b want 0",
               baud_div, valid, busy, err);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      bad++;
      $display("FAIL post_reset got busy=%b valid=%b want 0",
               busy, valid);
    end
  endtask

  task automatic test_fixed();
    fill(100);
    run_frame("fixed100", 1'b1);
    total++;
    if (exp_hold !== 32'd99) begin
      bad++;
      $display("FAIL fixed100_model got %0d want 99", exp_hold);
    end
  endtask

  task automatic test_pattern();
    ivs = '{17, 18, 17, 18, 17, 18, 17, 17};
    run_frame("p17_18", 1'b1);
    total++;
    if (baud_div !== 32'd16) begin
      bad++;
      $display("FAIL p17_18_div got %0d want 16", baud_div);
    end
    fill(50);
    run_frame("p50", 1'b1);
  endtask

  task automatic test_random();
    int p;
    for (int n = 0; n < 6; n++) begin
      p = int'($urandom_range(8, 120));
      for (int k = 0; k < 8; k++)
        ivs[k] = p + int'($urandom_range(0, 1));
      run_frame($sformatf("rand%0d_p%0d", n, p), 1'b1);
    end
  endtask

  task automatic test_timeout();
    int c, e0, v0;
    e0 = e_cnt;
    v0 = v_cnt;
    @(negedge clk);
    start = 1'b1;
    c = cyc;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL timeout_busy got %b want 1", busy);
    end
    for (int i = 0; i < 1100 && e_cnt == e0; i++)
      @(negedge clk);
    total++;
    if (e_cnt - e0 !== 1) begin
      bad++;
      $display("FAIL timeout_err_pulses got %0d want 1", e_cnt - e0);
    end
    total++;
    if (e_cyc - c !== MAXC + 1) begin
      bad++;
      $display("FAIL timeout_when got %0d want %0d",
               e_cyc - c, MAXC + 1);
    end
    total++;
    if (v_cnt !== v0 || baud_div !== exp_hold || busy !== 1'b0) begin
      bad++;
      $display("FAIL timeout_state got v=%0d div=%0d busy=%b want v=%0d div=%0d busy=0",
               v_cnt - v0, baud_div, busy, 0, exp_hold);
    end
  endtask

  task automatic test_min_div();
    fill(3);
    run_frame("min_div3", 1'b1);
    fill(4);
    run_frame("min_div4", 1'b1);
  endtask

  task automatic test_abort();
    int v0, e0;
    v0 = v_cnt;
    e0 = e_cnt;
    fill(40);
    arm();
    drive_edges(5);
    repeat (10) @(negedge clk);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL abort_busy got %b want 1", busy);
    end
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    rx = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if (v_cnt !== v0 || e_cnt !== e0) begin
      bad++;
      $display("FAIL abort_pulses got v=%0d e=%0d want 0 0",
               v_cnt - v0, e_cnt - e0);
    end
    run_frame("abort_rerun40", 1'b0);
  endtask

  task automatic test_reset_mid();
    fill(60);
    arm();
    drive_edges(4);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp_hold = '0;
    total++;
    if (baud_div !== exp_hold || valid !== 1'b0 ||
        busy !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid got div=%0d v=%b b=%b e=%b want 0",
               baud_div, valid, busy, err);
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    run_frame("after_reset60", 1'b1);
  endtask

  task automatic test_tol();
    fill(100);
    ivs[3] = 130;
    run_frame("tol130", 1'b1);
    fill(100);
    run_frame("tol_clean", 1'b1);
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_pattern();
    test_random();
    test_timeout();
    test_min_div();
    test_abort();
    test_reset_mid();
    test_tol();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
